dram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the byte-addressed data RAM. It shares the single RAM port between the CPU load/store unit (port 0) and the DMA/debug loader (port 1). It checks alignment before any access is issued, so misaligned requests never reach the RAM. It also translates a size/sign command into the RAM's one-hot w/h/b/z controls and returns read data with a valid pulse. It sits between the pipeline MEM stage / DMA engine and data_ram.

---
 rtl/dram_pkg.sv | 37 +++
 rtl/dram_arbiter_rr_arb2.sv | 40 ++++
 rtl/dram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the data-RAM arbiter and the MEM-stage exception
// logic: access-size encodings, arbiter FSM state encoding, and the alignment
// rule used to reject misaligned accesses before they reach the RAM.
// -----------------------------------------------------------------------------
package dram_pkg;

  // Access size as carried on size_x.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10,
    ERR   = 2'b11
  } state_e;

  // True when an access of the given size may start at an address with the
  // given low bits. The reserved size is never acceptable.
  function automatic logic aligned(input logic [1:0] size,
                                   input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr_lo[0];
      SZ_WORD: aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-request round-robin picker. When both requests are high the port not
// granted last wins; a single request always wins. The last-grant register
// resets to 1 so port 0 wins the first tie.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   req       request vector, bit x = port x
//   advance   a grant is being taken this cycle (updates last-grant)
//   grant     one-hot winner (all zero when no request)
//   valid     at least one request is pending
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       valid
);

  logic last;  // index of the port granted most recently

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    else              grant = req;
  end

  assign valid = |req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last <= 1'b1;
    else if (advance && valid) last <= grant[1];
  end

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares the single data-RAM port between the CPU load/store unit (port 0)
// and the DMA/debug loader (port 1). A request is granted in IDLE, checked
// for alignment, then either issued to the RAM for one cycle (ISSUE) and
// answered the cycle after (RESP), or answered immediately with an error
// (ERR) without touching the RAM.
//
// Ports (x = 0, 1):
//   clk, rst            clock, asynchronous active-high reset
//   req_x               request, held until gnt_x
//   we_x, size_x,       store flag, access size, sign-extend for loads,
//   sext_x, addr_x,     byte address and store data
//   wdata_x
//   gnt_x               one-cycle accept pulse (combinational, IDLE only)
//   rvalid_x            one-cycle completion pulse
//   rdata_x, err_x      load result / alignment error, valid with rvalid_x
//   ram_ena .. ram_din  RAM controls, non-zero only during ISSUE
//   ram_dout            RAM read data (registered inside the RAM)
// -----------------------------------------------------------------------------
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_0,
  input  logic             we_0,
  input  logic [1:0]       size_0,
  input  logic             sext_0,
  input  logic [DEPTH-1:0] addr_0,
  input  logic [31:0]      wdata_0,
  output logic             gnt_0,
  output logic             rvalid_0,
  output logic [31:0]      rdata_0,
  output logic             err_0,

  input  logic             req_1,
  input  logic             we_1,
  input  logic [1:0]       size_1,
  input  logic             sext_1,
  input  logic [DEPTH-1:0] addr_1,
  input  logic [31:0]      wdata_1,
  output logic             gnt_1,
  output logic             rvalid_1,
  output logic [31:0]      rdata_1,
  output logic             err_1,

  output logic             ram_ena,
  output logic             ram_wena,
  output logic             ram_w,
  output logic             ram_h,
  output logic             ram_b,
  output logic             ram_z,
  output logic [DEPTH-1:0] ram_addr,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout
);

  state_e           state;
  logic             port;       // port owning the access in flight
  logic [1:0]       arb_grant;
  logic             arb_valid;

  // Fields of the request selected by the arbiter this cycle.
  logic             sel;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic             sel_sext;
  logic [DEPTH-1:0] sel_addr;
  logic [31:0]      sel_wdata;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_1, req_0}),
    .advance (state == IDLE),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  assign sel       = arb_grant[1];
  assign sel_we    = sel ? we_1    : we_0;
  assign sel_size  = sel ? size_1  : size_0;
  assign sel_sext  = sel ? sext_1  : sext_0;
  assign sel_addr  = sel ? addr_1  : addr_0;
  assign sel_wdata = sel ? wdata_1 : wdata_0;

  // Grants are only offered from IDLE; reset masks them so every output reads
  // zero while reset is held.
  assign gnt_0 = (state == IDLE) && !rst && arb_grant[0];
  assign gnt_1 = (state == IDLE) && !rst && arb_grant[1];

  // Read data is forwarded straight from the RAM's output register during
  // RESP; an error response returns zero.
  assign rdata_0 = (rvalid_0 && !err_0) ? ram_dout : 32'd0;
  assign rdata_1 = (rvalid_1 && !err_1) ? ram_dout : 32'd0;

  // The RAM controls are loaded on the way into ISSUE and cleared on the way
  // out, so they are registered and asserted for exactly the ISSUE cycle.
  // rvalid/err are loaded on the way into RESP/ERR for the same reason.
  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      port     <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      err_0    <= 1'b0;
      err_1    <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_w    <= 1'b0;
      ram_h    <= 1'b0;
      ram_b    <= 1'b0;
      ram_z    <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      // Pulses and RAM controls default low; the state arms set them.
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      err_0    <= 1'b0;
      err_1    <= 1'b0;
      ram_ena  <= 1'b0;
      ram_wena <= 1'b0;
      ram_w    <= 1'b0;
      ram_h    <= 1'b0;
      ram_b    <= 1'b0;
      ram_z    <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;

      case (state)
        IDLE: begin
          if (arb_valid) begin
            port <= sel;
            if (aligned(sel_size, sel_addr[1:0])) begin
              state    <= ISSUE;
              ram_ena  <= 1'b1;
              ram_wena <= sel_we;
              ram_addr <= sel_addr;
              ram_din  <= sel_wdata;
              ram_w    <= (sel_size == SZ_WORD);
              ram_h    <= (sel_size == SZ_HALF);
              ram_b    <= (sel_size == SZ_BYTE);
              ram_z    <= sel_sext && (sel_size != SZ_WORD);
            end else begin
              // Misaligned or reserved size: answer without touching the RAM.
              state <= ERR;
              if (sel) begin
                rvalid_1 <= 1'b1;
                err_1    <= 1'b1;
              end else begin
                rvalid_0 <= 1'b1;
                err_0    <= 1'b1;
              end
            end
          end
        end

        ISSUE: begin
          state <= RESP;
          if (port) rvalid_1 <= 1'b1;
          else      rvalid_0 <= 1'b1;
        end

        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Directed bench for dram_arbiter. A behavioural RAM answers the DUT's RAM
// port; an independent transaction-level model (own byte array, grant
// schedule by cycle number) predicts every DUT output each cycle. Hand-computed
// literals pin the model on the key scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dram_arbiter;

  localparam int DEPTH = 3;
  localparam int NB    = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;

  logic             req_0 = 1'b0, we_0 = 1'b0, sext_0 = 1'b0;
  logic [1:0]       size_0 = '0;
  logic [DEPTH-1:0] addr_0 = '0;
  logic [31:0]      wdata_0 = '0;
  logic             gnt_0, rvalid_0, err_0;
  logic [31:0]      rdata_0;

  logic             req_1 = 1'b0, we_1 = 1'b0, sext_1 = 1'b0;
  logic [1:0]       size_1 = '0;
  logic [DEPTH-1:0] addr_1 = '0;
  logic [31:0]      wdata_1 = '0;
  logic             gnt_1, rvalid_1, err_1;
  logic [31:0]      rdata_1;

  logic             ram_ena, ram_wena, ram_w, ram_h, ram_b, ram_z;
  logic [DEPTH-1:0] ram_addr;
  logic [31:0]      ram_din;
  logic [31:0]      ram_dout = '0;

  dram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .size_0(size_0), .sext_0(sext_0),
    .addr_0(addr_0), .wdata_0(wdata_0), .gnt_0(gnt_0), .rvalid_0(rvalid_0),
    .rdata_0(rdata_0), .err_0(err_0),
    .req_1(req_1), .we_1(we_1), .size_1(size_1), .sext_1(sext_1),
    .addr_1(addr_1), .wdata_1(wdata_1), .gnt_1(gnt_1), .rvalid_1(rvalid_1),
    .rdata_1(rdata_1), .err_1(err_1),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_w(ram_w), .ram_h(ram_h),
    .ram_b(ram_b), .ram_z(ram_z), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      0: return 8'h11;  1: return 8'h22;  2: return 8'h33;  3: return 8'h80;
      4: return 8'h10;  5: return 8'h32;  6: return 8'h54;  default: return 8'h76;
    endcase
  endfunction

  // ---------------- behavioural data RAM (little-endian, sync read) --------
  logic [7:0] ram_mem [NB];

  function automatic logic [31:0] ram_fmt(input int a, input logic w,
                                          input logic h, input logic b,
                                          input logic z);
    logic [7:0] b0, b1, b2, b3;
    b0 = ram_mem[a % NB];       b1 = ram_mem[(a + 1) % NB];
    b2 = ram_mem[(a + 2) % NB]; b3 = ram_mem[(a + 3) % NB];
    if (w)      return {b3, b2, b1, b0};
    else if (h) return {{16{z & b1[7]}}, b1, b0};
    else if (b) return {{24{z & b0[7]}}, b0};
    else        return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (ram_ena) begin
      ram_dout <= ram_fmt(int'(ram_addr), ram_w, ram_h, ram_b, ram_z);
      if (ram_wena) begin
        ram_mem[int'(ram_addr) % NB] <= ram_din[7:0];
        if (ram_h || ram_w) ram_mem[(int'(ram_addr) + 1) % NB] <= ram_din[15:8];
        if (ram_w) begin
          ram_mem[(int'(ram_addr) + 2) % NB] <= ram_din[23:16];
          ram_mem[(int'(ram_addr) + 3) % NB] <= ram_din[31:24];
        end
      end
    end
  end

  // ---------------- transaction-level model --------------------------------
  logic [7:0]  mdl_mem [NB];
  bit          m_last = 1'b1;
  int          m_free_at = 0, m_issue_at = -1, m_resp_at = -1;
  bit          m_port, m_we, m_sext, m_err;
  int          m_size, m_addr;
  logic [31:0] m_wdata, m_rdata;

  function automatic logic [31:0] mdl_load(input int a, input int sz, input bit sx);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl_mem[(a + i) % NB]) << (8 * i));
    if (sx && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Observations used by the literal checks.
  int          obs_gnt_cyc [2], obs_rv_cyc [2], obs_rv_cnt [2];
  logic [31:0] obs_rdata [2];
  logic        obs_err [2];
  int          obs_ena_cyc = -1, ena_cnt = 0;
  logic [5:0]  obs_ctl;
  int          obs_addr;
  bit          gnt_log [$];
  int          gnt_cyc_log [$];

  initial begin : compare
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_rd0, e_rd1, e_addr, e_din;
    logic [5:0]  e_ctl;
    bit          win, ok;
    for (int i = 0; i < NB; i++) mdl_mem[i] = init_byte(i);
    for (int i = 0; i < 2; i++) begin
      obs_gnt_cyc[i] = -1; obs_rv_cyc[i] = -1; obs_rv_cnt[i] = 0;
      obs_rdata[i] = '0; obs_err[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      e_gnt = '0; e_rv = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
      e_ctl = '0; e_addr = '0; e_din = '0; win = 1'b0;
      if (rst) begin
        m_last = 1'b1; m_free_at = cyc; m_issue_at = -1; m_resp_at = -1;
      end else begin
        if (cyc >= m_free_at && (req_0 || req_1)) begin
          win = (req_0 && req_1) ? !m_last : req_1;
          e_gnt[win] = 1'b1;
        end
        if (cyc == m_issue_at) begin
          e_ctl  = {1'b1, m_we, m_size == 2, m_size == 1, m_size == 0,
                    m_sext && m_size != 2};
          e_addr = m_addr;
          e_din  = m_wdata;
        end
        if (cyc == m_resp_at) begin
          e_rv[m_port]  = 1'b1;
          e_err[m_port] = m_err;
          if (m_port) e_rd1 = m_err ? 32'd0 : m_rdata;
          else        e_rd0 = m_err ? 32'd0 : m_rdata;
        end
      end

      check("gnt",     {gnt_1, gnt_0}, e_gnt);
      check("rvalid",  {rvalid_1, rvalid_0}, e_rv);
      check("err",     {err_1, err_0}, e_err);
      check("rdata_0", rdata_0, e_rd0);
      check("rdata_1", rdata_1, e_rd1);
      check("ram_ctl", {ram_ena, ram_wena, ram_w, ram_h, ram_b, ram_z}, e_ctl);
      check("ram_addr", 32'(ram_addr), e_addr);
      check("ram_din", ram_din, e_din);

      for (int p = 0; p < 2; p++) begin
        if (p == 0 ? gnt_0 : gnt_1) begin
          obs_gnt_cyc[p] = cyc;
          gnt_log.push_back(p[0]);
          gnt_cyc_log.push_back(cyc);
        end
        if (p == 0 ? rvalid_0 : rvalid_1) begin
          obs_rv_cyc[p] = cyc;
          obs_rv_cnt[p]++;
          obs_rdata[p] = (p == 0) ? rdata_0 : rdata_1;
          obs_err[p]   = (p == 0) ? err_0 : err_1;
        end
      end
      if (ram_ena) begin
        obs_ena_cyc = cyc; ena_cnt++;
        obs_ctl  = {ram_ena, ram_wena, ram_w, ram_h, ram_b, ram_z};
        obs_addr = int'(ram_addr);
      end

      if (!rst) begin
        if (cyc == m_issue_at) begin
          m_rdata = mdl_load(m_addr, m_size, m_sext);
          if (m_we)
            for (int i = 0; i < (1 << m_size); i++)
              mdl_mem[(m_addr + i) % NB] = m_wdata[8 * i +: 8];
        end
        if (e_gnt != 2'b00) begin
          m_port  = win;
          m_we    = win ? we_1 : we_0;
          m_size  = int'(win ? size_1 : size_0);
          m_sext  = win ? sext_1 : sext_0;
          m_addr  = int'(win ? addr_1 : addr_0);
          m_wdata = win ? wdata_1 : wdata_0;
          m_last  = win;
          ok = (m_size != 3) && (m_addr % (1 << m_size) == 0);
          if (ok) begin
            m_err = 1'b0; m_issue_at = cyc + 1; m_resp_at = cyc + 2; m_free_at = cyc + 3;
          end else begin
            m_err = 1'b1; m_issue_at = -1; m_resp_at = cyc + 1; m_free_at = cyc + 2;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic drive(input bit p, input bit rq, input bit we,
                       input logic [1:0] sz, input bit sx,
                       input logic [DEPTH-1:0] a, input logic [31:0] wd);
    if (p) begin
      req_1 = rq; we_1 = we; size_1 = sz; sext_1 = sx; addr_1 = a; wdata_1 = wd;
    end else begin
      req_0 = rq; we_0 = we; size_0 = sz; sext_0 = sx; addr_0 = a; wdata_0 = wd;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends
  // the grant cycle, with the request dropped.
  task automatic do_req(input bit p, input bit we, input logic [1:0] sz,
                        input bit sx, input logic [DEPTH-1:0] a,
                        input logic [31:0] wd);
    bit got = 1'b0;
    drive(p, 1'b1, we, sz, sx, a, wd);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = p ? gnt_1 : gnt_0;
    end
    if (!got) begin
      n_vec++; n_mis++;
      $display("FAIL gnt_timeout_p%0d: no grant within 60 cycles, expected a grant", p);
    end
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int ena_before, rv_before;
    for (int i = 0; i < NB; i++) ram_mem[i] <= init_byte(i);
    idle(3);
    rst = 1'b0;
    idle(1);

    // Port 0 word load at 4, no contention.
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 3'd4, 32'd0);
    idle(3);
    check("p0_word_rdata",   obs_rdata[0], 32'h7654_3210);
    check("p0_word_latency", obs_rv_cyc[0] - obs_gnt_cyc[0], 2);
    check("p0_word_issue",   obs_ena_cyc - obs_gnt_cyc[0], 1);
    check("p0_word_ctl",     obs_ctl, 6'b101000);
    check("p0_word_addr",    obs_addr, 4);

    // Port 1 signed byte load of 0x80 at 3.
    do_req(1'b1, 1'b0, 2'b00, 1'b1, 3'd3, 32'd0);
    idle(3);
    check("p1_sbyte_rdata", obs_rdata[1], 32'hFFFF_FF80);
    check("p1_sbyte_ctl",   obs_ctl, 6'b100011);

    // Both ports request together and keep requesting.
    gnt_log.delete();
    gnt_cyc_log.delete();
    fork
      begin
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 3'd4, 32'd0);
        do_req(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 32'd0);
      end
      begin
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 3'd2, 32'd0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 3'd0, 32'd0);
      end
    join
    idle(4);
    check("alt_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("alt_port_%0d", i), 32'(gnt_log[i]), i % 2);
        if (i > 0)
          check($sformatf("alt_gap_%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], 3);
      end
    end

    // Port 0 misaligned half store at 1: immediate error, RAM untouched.
    ena_before = ena_cnt;
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 3'd1, 32'h0000_ABCD);
    idle(3);
    check("p0_mis_err",     obs_err[0], 1'b1);
    check("p0_mis_latency", obs_rv_cyc[0] - obs_gnt_cyc[0], 1);
    check("p0_mis_rdata",   obs_rdata[0], 32'd0);
    check("p0_mis_no_ram",  ena_cnt, ena_before);

    // Port 1 reserved size: error.
    do_req(1'b1, 1'b0, 2'b11, 1'b0, 3'd0, 32'd0);
    idle(3);
    check("p1_rsvd_err", obs_err[1], 1'b1);

    // Port 1 word store, then port 0 unsigned half load of the upper half.
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 3'd0, 32'hDEAD_BEEF);
    idle(3);
    check("p1_store_err", obs_err[1], 1'b0);
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 3'd2, 32'd0);
    idle(3);
    check("p0_half_rdata", obs_rdata[0], 32'h0000_DEAD);

    // Reset while a store sits in ISSUE.
    rv_before = obs_rv_cnt[1];
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 3'd4, 32'hCAFE_F00D);
    check("rst_in_issue", ram_ena, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_ram_ena",  ram_ena, 1'b0);
    check("rst_ram_wena", ram_wena, 1'b0);
    check("rst_rvalid_1", rvalid_1, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("rst_no_rvalid", obs_rv_cnt[1], rv_before);
    check("rst_no_write",  {ram_mem[7], ram_mem[6], ram_mem[5], ram_mem[4]},
          32'h7654_3210);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 3'd4, 32'd0);
    idle(3);
    check("post_rst_rdata", obs_rdata[0], 32'h7654_3210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
